// File: rtl/os256_resample_ctrl_pkg.sv
// rtl/os256_resample_ctrl_pkg.sv - shared types and constants for the os256 resampler sequencer
//
// Contents: FSM state encoding, tap latency, fill depth, round constant,
// saturation limits and the 18-bit to 16-bit saturating helper.
package os256_resample_ctrl_pkg;

  localparam int TAPLAT    = 3;
  localparam int PIPEW     = TAPLAT + 1;
  localparam int FILL_TAPS = 4;

  localparam logic signed [33:0] ROUND_K = 34'sh8000;
  localparam logic        [15:0] SAT_MAX = 16'h7FFF;
  localparam logic        [15:0] SAT_MIN = 16'h8000;
  localparam logic signed [17:0] R_MAX   = 18'sd32767;
  localparam logic signed [17:0] R_MIN   = -18'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_EMIT    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_ADVANCE = 3'd5
  } state_t;

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    logic [15:0] res;
    if (v > R_MAX) begin
      res = SAT_MAX;
    end else if (v < R_MIN) begin
      res = SAT_MIN;
    end else begin
      res = v[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/os256_resample_ctrl_sum4_sat.sv
// rtl/os256_resample_ctrl_sum4_sat.sv - four-product adder with round-half-up and 16-bit saturation
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            capture the rounded, saturated sum of k0..k3
//   k0..k3          signed tap products, S1:INT15:DEC16
//   q               registered signed 16-bit result, held between loads
module os256_resample_ctrl_sum4_sat
  import os256_resample_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  output logic [15:0] q
);

  logic signed [33:0] sum;
  logic signed [33:0] biased;
  logic signed [17:0] r;

  // 34 bits hold four full-scale negative products (-2^33) without wrap.
  always_comb begin
    sum    = $signed({{2{k0[31]}}, k0}) + $signed({{2{k1[31]}}, k1})
           + $signed({{2{k2[31]}}, k2}) + $signed({{2{k3[31]}}, k3});
    biased = sum + ROUND_K;
    r      = 18'(biased >>> 16);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= sat16(r);
    end
  end

endmodule

// File: rtl/os256_resample_ctrl.sv
// rtl/os256_resample_ctrl.sv - phase accumulator and tap-chain sequencer for the 4-tap Lanczos-2 resampler
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   enable                         run request; rising from idle re-primes the tap chain
//   step                           Q8.16 input samples consumed per output, sampled at EMIT
//   in_valid, in_ready, in_data    upstream sample stream
//   out_valid, out_ready, out_data resampled output stream
//   tap_shift, tap_din, tap_phase  drive to the external tap chain
//   kout0..kout3                   tap products, S1:INT15:DEC16
//   busy                           sequencer active, or a result in flight or held
module os256_resample_ctrl
  import os256_resample_ctrl_pkg::*;
#(
  parameter int STEPW = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [STEPW-1:0] step,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic             tap_shift,
  output logic [15:0]      tap_din,
  output logic [7:0]       tap_phase,
  input  logic [31:0]      kout0,
  input  logic [31:0]      kout1,
  input  logic [31:0]      kout2,
  input  logic [31:0]      kout3,
  output logic             busy
);

  // Integer step part plus carry can reach 2^(STEPW-16).
  localparam int CNTW = STEPW - 15;

  state_t           state;
  state_t           state_nx;
  logic [15:0]      acc;
  logic [CNTW-1:0]  cnt;
  logic [PIPEW-1:0] pipe;
  logic [16:0]      acc_sum;
  logic             accept;
  logic             last_take;
  logic             emit_ok;

  assign acc_sum   = {1'b0, acc} + {1'b0, step[15:0]};
  assign accept    = in_valid && in_ready;
  assign last_take = accept && (cnt == CNTW'(1));
  assign emit_ok   = (pipe == '0) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (enable) state_nx = ST_FILL;
      ST_FILL:    if (last_take) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (emit_ok) begin
          state_nx = ST_EMIT;
        end
      end
      ST_EMIT:    state_nx = ST_HOLD;
      ST_HOLD:    state_nx = (cnt != '0) ? ST_ADVANCE : ST_WAIT;
      ST_ADVANCE: if (last_take) state_nx = ST_WAIT;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = ((state == ST_FILL) || (state == ST_ADVANCE)) && (cnt != '0);
    tap_shift = in_valid && in_ready;
    tap_din   = in_data;
    tap_phase = acc[15:8];
    busy      = (state != ST_IDLE) || (pipe != '0) || out_valid;
  end

  // The phase presented during EMIT is the pre-update acc; the taps sample it
  // on the same edge that advances acc.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if ((state == ST_IDLE) && enable) begin
      acc <= '0;
      cnt <= CNTW'(FILL_TAPS);
    end else if (state == ST_EMIT) begin
      acc <= acc_sum[15:0];
      cnt <= CNTW'(step[STEPW-1:16]) + CNTW'(acc_sum[16]);
    end else if (accept) begin
      cnt <= cnt - CNTW'(1);
    end
  end

  // pipe[0] is set during the EMIT cycle itself, so pipe[PIPEW-1] marks the
  // cycle kout is valid and the pipe is empty again one cycle later, which
  // lets the next EMIT follow five clocks after the previous one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe      <= '0;
      out_valid <= 1'b0;
    end else begin
      pipe <= {pipe[PIPEW-2:0], state_nx == ST_EMIT};
      if (pipe[PIPEW-1]) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  os256_resample_ctrl_sum4_sat u_sum (
    .clk   (clk),
    .reset (reset),
    .load  (pipe[PIPEW-1]),
    .k0    (kout0),
    .k1    (kout1),
    .k2    (kout2),
    .k3    (kout3),
    .q     (out_data)
  );

endmodule

// File: tb/tb_os256_resample_ctrl.sv
// tb/tb_os256_resample_ctrl.sv - self-checking bench for os256_resample_ctrl
module tb_os256_resample_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] step;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        tap_shift;
  logic [15:0] tap_din;
  logic [7:0]  tap_phase;
  logic [31:0] kout0, kout1, kout2, kout3;
  logic        busy;

  logic        ovr = 1'b0;
  logic [31:0] ko [4];
  logic [6:0]  shc = '0;
  logic [14:0] p1 = '0, p2 = '0, p3 = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  os256_resample_ctrl #(.STEPW(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .step      (step),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .tap_shift (tap_shift),
    .tap_din   (tap_din),
    .tap_phase (tap_phase),
    .kout0     (kout0),
    .kout1     (kout1),
    .kout2     (kout2),
    .kout3     (kout3),
    .busy      (busy)
  );

  // Tap chain stand-in: 3-clock latency from phase, product encodes
  // {shift count, phase} as an integer so out_data reveals both.
  always @(posedge clk) begin
    if (tap_shift) shc <= shc + 7'd1;
    p1 <= {shc, tap_phase};
    p2 <= p1;
    p3 <= p2;
  end

  assign kout0 = ovr ? ko[0] : {1'b0, p3, 16'h0000};
  assign kout1 = ovr ? ko[1] : 32'h0;
  assign kout2 = ovr ? ko[2] : 32'h0;
  assign kout3 = ovr ? ko[3] : 32'h0;

  task automatic wait_output(output logic [15:0] data, output int lat,
                             output logic emit_shift, output logic ok);
    logic [63:0] hist;
    data = '0; lat = 0; emit_shift = 1'b0; ok = 1'b0; hist = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      hist[k] = tap_shift;
      if (out_valid) begin
        data = out_data;
        lat  = k + 1;
        if (k >= 4) emit_shift = hist[k-4] | hist[k-3];
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_run(output logic idle);
    idle   = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    in_data = 16'hA5C3;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h required 0000", out_data); end
    n_tests++; if (tap_shift !== 1'b0) begin n_fail++; $display("FAIL reset_tap_shift got %b required 0", tap_shift); end
    n_tests++; if (tap_phase !== 8'h00) begin n_fail++; $display("FAIL reset_tap_phase got %h required 00", tap_phase); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy); end
    n_tests++; if (tap_din !== 16'hA5C3) begin n_fail++; $display("FAIL reset_tap_din got %h required a5c3", tap_din); end
  endtask

  task automatic test_unity();
    logic [6:0] b; logic [15:0] d; logic [15:0] e; int lat; logic es, ok, idle;
    b = shc; step = 24'h010000; out_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_output(d, lat, es, ok);
      e = {1'b0, 7'(b + 7'(i + 4)), 8'h00};
      n_tests++; if (!ok || d !== e) begin n_fail++; $display("FAIL unity_data[%0d] got %h required %h", i, d, e); end
      if (i == 0) begin
        n_tests++; if (lat != 10) begin n_fail++; $display("FAIL unity_first_latency got %0d required 10", lat); end
      end
      n_tests++; if (es !== 1'b0) begin n_fail++; $display("FAIL unity_emit_shift[%0d] got %b required 0", i, es); end
    end
    stop_run(idle);
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL unity_idle got %b required 1", idle); end
  endtask

  task automatic test_upsample();
    logic [6:0] b; logic [15:0] d; logic [15:0] e; int lat; logic es, ok, idle;
    logic [7:0] ph [6];
    int off [6];
    ph  = '{8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80};
    off = '{4, 4, 5, 5, 6, 6};
    b = shc; step = 24'h008000; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_output(d, lat, es, ok);
      e = {1'b0, 7'(b + 7'(off[i])), ph[i]};
      n_tests++; if (!ok || d !== e) begin n_fail++; $display("FAIL up2_data[%0d] got %h required %h", i, d, e); end
    end
    stop_run(idle);
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL up2_idle got %b required 1", idle); end
  endtask

  task automatic test_decimate();
    logic [6:0] b; logic [15:0] d; logic [15:0] e; int lat; logic es, ok, idle;
    b = shc; step = 24'h020000; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_output(d, lat, es, ok);
      e = {1'b0, 7'(b + 7'(4 + 2 * i)), 8'h00};
      n_tests++; if (!ok || d !== e) begin n_fail++; $display("FAIL dec2_data[%0d] got %h required %h", i, d, e); end
      n_tests++; if (es !== 1'b0) begin n_fail++; $display("FAIL dec2_emit_shift[%0d] got %b required 0", i, es); end
    end
    stop_run(idle);
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL dec2_idle got %b required 1", idle); end
  endtask

  task automatic test_arith();
    logic [15:0] d; int lat; logic es, ok, idle;
    logic [31:0] k0v [6];
    logic [31:0] kav [6];
    logic [15:0] ev [6];
    k0v = '{32'h00008000, 32'hFFFF8000, 32'h7FFF0000, 32'h80000000, 32'h00018000, 32'hFFFE8000};
    kav = '{32'h0,        32'h0,        32'h7FFF0000, 32'h80000000, 32'h0,        32'h0};
    ev  = '{16'h0001,     16'h0000,     16'h7FFF,     16'h8000,     16'h0002,     16'hFFFF};
    step = 24'h010000; ovr = 1'b1;
    ko[0] = k0v[0]; ko[1] = kav[0]; ko[2] = kav[0]; ko[3] = kav[0];
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_output(d, lat, es, ok);
      n_tests++; if (!ok || d !== ev[i]) begin n_fail++; $display("FAIL arith[%0d] got %h required %h", i, d, ev[i]); end
      if (i < 5) begin
        ko[0] = k0v[i+1]; ko[1] = kav[i+1]; ko[2] = kav[i+1]; ko[3] = kav[i+1];
      end
    end
    stop_run(idle);
    ovr = 1'b0;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL arith_idle got %b required 1", idle); end
  endtask

  task automatic test_backpressure();
    logic [6:0] b; logic [15:0] d; logic [15:0] e; int lat; logic es, ok, idle;
    b = shc; step = 24'h010000; out_ready = 1'b0; enable = 1'b1;
    wait_output(d, lat, es, ok);
    e = {1'b0, 7'(b + 7'd4), 8'h00};
    n_tests++; if (!ok || lat != 10) begin n_fail++; $display("FAIL bp_first_latency got %0d required 10", lat); end
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL bp_first_data got %h required %h", d, e); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_data !== e) begin n_fail++; $display("FAIL bp_hold[%0d] got valid=%b data=%h required valid=1 data=%h", i, out_valid, out_data, e); end
      n_tests++; if (in_ready !== 1'b0 || tap_shift !== 1'b0) begin n_fail++; $display("FAIL bp_stall[%0d] got in_ready=%b tap_shift=%b required 0 0", i, in_ready, tap_shift); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d] got %b required 1", i, busy); end
    end
    out_ready = 1'b1;
    wait_output(d, lat, es, ok);
    e = {1'b0, 7'(b + 7'd5), 8'h00};
    n_tests++; if (!ok || lat != 5) begin n_fail++; $display("FAIL bp_release_latency got %0d required 5", lat); end
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL bp_release_data got %h required %h", d, e); end
    stop_run(idle);
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle got %b required 1", idle); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] b; logic [15:0] d; logic [15:0] e; int lat; logic es, ok, idle, found, quiet;
    step = 24'h020000; out_ready = 1'b1; enable = 1'b1;
    wait_output(d, lat, es, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_first_output got none required one"); end
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tap_shift) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_find_advance got %b required 1", found); end
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b required 0", busy); end
    n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_out_data got %h required 0000", out_data); end
    reset = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    n_tests++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL rst_stray_valid got %b required 1", quiet); end
    b = shc; step = 24'h010000; enable = 1'b1;
    wait_output(d, lat, es, ok);
    e = {1'b0, 7'(b + 7'd4), 8'h00};
    n_tests++; if (!ok || lat != 10) begin n_fail++; $display("FAIL rst_reprime_latency got %0d required 10", lat); end
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL rst_reprime_data got %h required %h", d, e); end
    stop_run(idle);
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b required 1", idle); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; step = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    test_unity();
    test_upsample();
    test_decimate();
    test_arith();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/os256_resample_ctrl.md
# os256_resample_ctrl

Sequencer for the four-tap Lanczos-2 interpolator chain (t-1, t0, t1, t2 tap instances). It runs a fractional phase accumulator and feeds input samples into the tap shift chain. It broadcasts the 8-bit phase to all taps, sums the four tap products, then rounds and saturates the sum to a 16-bit output stream. It sits between the upstream sample source and the downstream consumer of the resampled stream; the taps are instantiated alongside it, not inside it.

## Interface
- STEPW, 24: step width, unsigned Q8.16 (input samples consumed per output sample).
- TAPLAT, 3: tap latency in clocks, from phase applied to kout valid. Fixed by the tap pipeline.

- clk  in  1  clock, all logic positive edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request. Rising from idle clears the accumulator and re-primes the chain.
- step  in  STEPW  resample step; sampled at each EMIT.
- in_valid  in  1  upstream sample valid.
- in_data  in  16  upstream signed sample.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- out_valid  out  1  result valid.
- out_data  out  16  signed resampled sample.
- out_ready  in  1  downstream accept.
- tap_shift  out  1  shift strobe to all taps; equals in_valid && in_ready.
- tap_din  out  16  in_data pass-through to the chain head.
- tap_phase  out  8  phase to all taps; equals acc[15:8].
- kout0..kout3  in  32 each  tap products, S1:INT15:DEC16.
- busy  out  1  FSM not in IDLE, or a result is in flight or held.

## Operation
- States:
  - IDLE: wait for enable.
  - FILL: cnt=4, then accept 4 samples.
  - WAIT: enter EMIT when the pipe is empty and (!out_valid || out_ready).
  - EMIT: 1 cycle.
  - HOLD: 1 cycle.
  - ADVANCE: accept cnt samples.
- Accumulator acc, 16-bit fraction.
  - In EMIT: {carry, acc} <= acc + step[15:0].
  - cnt <= step[23:16] + carry (9 bits, range 0..256).
- HOLD → ADVANCE if cnt != 0, else → WAIT. ADVANCE → WAIT when the last sample is accepted.
- in_ready = (FILL or ADVANCE) && cnt != 0. cnt decrements per accepted sample. Sample gaps (in_valid low) simply stall.
- enable low is seen only in WAIT or IDLE; the FSM then goes to IDLE. An output in flight still completes and is delivered.
- step = 0 is legal: the same tap data is re-interpolated with an unchanged phase, and no samples are consumed.
- Sum path:
  - sum = sign-extended kout0+kout1+kout2+kout3, 34 bits.
  - r = (sum + 0x8000) >>> 16 (arithmetic shift, round-half-up).
  - Saturate r to [-32768, 32767].
- Reset values: in_ready 0, out_valid 0, out_data 0, tap_shift 0, tap_phase 0, busy 0. Also state IDLE, acc 0, cnt 0, pipe flags 0.

## Timing
- EMIT at cycle T:
  - the taps sample tap_phase at the end of T;
  - kout is valid in T+3;
  - the registered sum drives out_valid=1 and out_data in T+4.
- tap_shift is forbidden in T and T+1 (HOLD), because the tap data register must pair with the phase of cycle T. The earliest shift is T+2.
- A 4-bit pipe-valid shift register tracks the in-flight result. EMIT requires it to be all zero.
- out_valid clears on out_valid && out_ready. The same cycle can qualify WAIT → EMIT.
- Minimum output period is 5 clocks (EMIT at T, next EMIT at T+5 with out_ready held high).
- out_ready low: out_data is held stable. At most one result is in flight. The ADVANCE in progress completes, and no new EMIT occurs.
- Reset asserted mid-operation: all outputs are at reset values next cycle, pipe flags are cleared (no stray out_valid), and the next enable re-primes with FILL. The taps are not reset.

## Structure
- Shared include os256_defs.vh holds:
  - state encodings;
  - TAPLAT;
  - the round constant 0x8000;
  - saturation limits 16'sh7FFF and 16'sh8000.
- Optional sub-module os256_sum4_sat: 4-input adder, round and saturate, one register stage.
- FSM, accumulator and handshake logic are inline.

## Test plan
- Prime and unity step:
  - Stimulus: enable=1, step=0x010000, 4 samples accepted in FILL.
  - Required: tap_phase=0x00 at every EMIT, exactly one tap_shift per output, out_valid first at 4 clocks after the first EMIT.
- Upsample 2x:
  - Stimulus: step=0x008000.
  - Required: tap_phase alternates 0x00, 0x80; one sample accepted per two outputs.
- Decimate 2x:
  - Stimulus: step=0x020000.
  - Required: two tap_shift pulses in ADVANCE per output; none in EMIT or HOLD.
- Arithmetic (bench drives kout directly):
  - kout0=0x00008000, others 0 → out_data=1.
  - kout0=0xFFFF8000, others 0 → out_data=0.
  - All four = 0x7FFF0000 → 32767.
  - All four = 0x80000000 → -32768.
- Backpressure:
  - Stimulus: out_ready=0 for 20 clocks.
  - Required: out_data stable, no EMIT, in_ready low after the current ADVANCE. Release → next EMIT in the same cycle.
- Reset during ADVANCE:
  - Required: next cycle out_valid=0, in_ready=0, busy=0.
  - Then enable → exactly 4 samples accepted before the first EMIT, with tap_phase=0x00.
